// File: rtl/temp_freq_pkg.sv
// Shared types and helpers for the multi-channel ring-oscillator frequency counter.
package temp_freq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLR    = 2'd1,
        GATE   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chan_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/temp_freq_counter_mc_chan.sv
// One oscillator channel: synchroniser, rising-edge detector, saturating counter, sticky overflow.
module temp_freq_chan #(
    parameter int CNT_W       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ref_clk,
    input  logic             reset_n,
    input  logic             sense_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_pulse;

    // Synchroniser chain plus previous-value flop; free-running so edges seen before the gate are not counted.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sense_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Count detected edges while gated; hold at all-ones and remember that an edge was lost.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en && edge_pulse) begin
            if (&count) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/temp_freq_counter_mc.sv
// Top level: measurement FSM, gate down-counter and channel-by-channel result unload.
module temp_freq_counter_mc
    import temp_freq_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 20,
    parameter int GATE_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        ref_clk,
    input  logic                        reset_n,
    input  logic [NCH-1:0]              sense_in,
    input  logic [GATE_W-1:0]           gate_len,
    input  logic                        mode,
    input  logic                        start,
    input  logic                        stop,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [chan_idx_w(NCH)-1:0]  res_chan,
    output logic [CNT_W-1:0]            res_count,
    output logic                        res_ovf,
    output logic                        meas_done
);

    localparam int               IDX_W   = chan_idx_w(NCH);
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NCH - 1);

    state_t            state;
    state_t            state_next;
    logic [GATE_W-1:0] gate_cnt;
    logic              cont;
    logic              stop_pend;
    logic [IDX_W-1:0]  chan_idx;
    logic              chan_clr;
    logic              chan_en;
    logic [CNT_W-1:0]  chan_count [NCH];
    logic [NCH-1:0]    chan_ovf;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        temp_freq_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .ref_clk  (ref_clk),
            .reset_n  (reset_n),
            .sense_in (sense_in[i]),
            .clr      (chan_clr),
            .en       (chan_en),
            .count    (chan_count[i]),
            .ovf      (chan_ovf[i])
        );
    end

    // State register.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs; continuous mode loops back to CLR unless a stop was seen.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        res_valid  = 1'b0;
        meas_done  = 1'b0;
        chan_clr   = 1'b0;
        chan_en    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                chan_clr   = 1'b1;
                state_next = GATE;
            end
            GATE: begin
                chan_en = 1'b1;
                if (gate_cnt == GATE_W'(1)) begin
                    state_next = UNLOAD;
                end
            end
            UNLOAD: begin
                res_valid = 1'b1;
                if (res_ready && (chan_idx == LAST_CH)) begin
                    meas_done  = 1'b1;
                    state_next = (cont && !stop_pend && !stop) ? CLR : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Gate length is loaded while clearing (zero means one cycle) and counted down through GATE.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            gate_cnt <= '0;
        end else if (state == CLR) begin
            gate_cnt <= (gate_len == '0) ? GATE_W'(1) : gate_len;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt - GATE_W'(1);
        end
    end

    // Continuous flag latched with start; a simultaneous stop turns the request into single-shot.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            cont <= 1'b0;
        end else if ((state == IDLE) && start) begin
            cont <= mode & ~stop;
        end
    end

    // Stop request remembered while busy and forgotten once the FSM is back in IDLE.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            stop_pend <= 1'b0;
        end else if (state_next == IDLE) begin
            stop_pend <= 1'b0;
        end else if (stop && (state != IDLE)) begin
            stop_pend <= 1'b1;
        end
    end

    // Unload pointer advances on every accepted result and wraps after the last channel.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            chan_idx <= '0;
        end else if ((state == UNLOAD) && res_ready) begin
            chan_idx <= (chan_idx == LAST_CH) ? '0 : chan_idx + IDX_W'(1);
        end
    end

    // Counters are frozen outside GATE, so the result is read straight from the selected channel.
    always_comb begin
        res_chan  = '0;
        res_count = '0;
        res_ovf   = 1'b0;
        if (state == UNLOAD) begin
            res_chan  = chan_idx;
            res_count = chan_count[chan_idx];
            res_ovf   = chan_ovf[chan_idx];
        end
    end

endmodule

// File: tb/tb_temp_freq_counter_mc.sv
// Self-checking bench for temp_freq_counter_mc with a cycle-level behavioural model.
module tb_temp_freq_counter_mc;

    localparam int NCH         = 4;
    localparam int CNT_W       = 4;
    localparam int GATE_W      = 12;
    localparam int SYNC_STAGES = 2;
    localparam int CMAX        = (1 << CNT_W) - 1;
    localparam int HIST_N      = 8192;

    logic              ref_clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    sense_in;
    logic [GATE_W-1:0] gate_len;
    logic              mode;
    logic              start;
    logic              stop;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_chan;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;
    logic              meas_done;

    always #5 ref_clk = ~ref_clk;

    temp_freq_counter_mc #(
        .NCH         (NCH),
        .CNT_W       (CNT_W),
        .GATE_W      (GATE_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .ref_clk   (ref_clk),
        .reset_n   (reset_n),
        .sense_in  (sense_in),
        .gate_len  (gate_len),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_chan  (res_chan),
        .res_count (res_count),
        .res_ovf   (res_ovf),
        .meas_done (meas_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Oscillator generator: period 0 = held low, negative = held high, else square wave of that period.
    int per [NCH];
    int gen_cnt = 0;
    initial begin
        sense_in = '0;
        forever begin
            @(posedge ref_clk);
            #1;
            gen_cnt++;
            for (int c = 0; c < NCH; c++) begin
                if (per[c] == 0) sense_in[c] = 1'b0;
                else if (per[c] < 0) sense_in[c] = 1'b1;
                else sense_in[c] = ((gen_cnt % per[c]) < (per[c] / 2));
            end
        end
    end

    // Behavioural model: tracks measurement windows by edge number and counts input edges from history.
    bit [NCH-1:0] hist [HIST_N];
    int m_k = 0;
    bit m_started = 0;
    bit m_active = 0;
    bit m_unload = 0;
    bit m_cont = 0;
    bit m_stop_pend = 0;
    int m_clr_edge = 0;
    int m_g = 1;
    int m_next_ch = 0;
    int m_cnt [NCH];
    bit m_ovf [NCH];

    function automatic void open_gate();
        m_clr_edge = m_k;
        m_g = (gate_len == 0) ? 1 : int'(gate_len);
    endfunction

    function automatic void settle_counts();
        for (int c = 0; c < NCH; c++) begin
            int n = 0;
            for (int j = m_clr_edge + 2 - SYNC_STAGES; j <= m_clr_edge + m_g + 1 - SYNC_STAGES; j++) begin
                if (hist[j % HIST_N][c] && !hist[(j - 1) % HIST_N][c]) n++;
            end
            m_cnt[c] = (n > CMAX) ? CMAX : n;
            m_ovf[c] = (n > CMAX);
        end
    endfunction

    always @(posedge ref_clk) begin
        m_k = m_k + 1;
        m_started = 1;
        if (!reset_n) begin
            hist[m_k % HIST_N] = '0;
            m_active = 0;
            m_unload = 0;
            m_stop_pend = 0;
        end else begin
            hist[m_k % HIST_N] = sense_in;
            if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_cont = mode && !stop;
                    m_stop_pend = 0;
                    open_gate();
                end
            end else begin
                if (stop) m_stop_pend = 1;
                if (m_unload) begin
                    if (res_ready) begin
                        if (m_next_ch == NCH - 1) begin
                            m_unload = 0;
                            if (m_cont && !m_stop_pend) begin
                                open_gate();
                            end else begin
                                m_active = 0;
                                m_stop_pend = 0;
                            end
                        end else begin
                            m_next_ch++;
                        end
                    end
                end else if (m_k == m_clr_edge + m_g + 1) begin
                    settle_counts();
                    m_unload = 1;
                    m_next_ch = 0;
                end
            end
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge ref_clk) begin
        if (m_started) begin
            check_val("busy", busy, m_active);
            check_val("res_valid", res_valid, m_unload);
            check_val("res_chan", res_chan, m_unload ? m_next_ch : 0);
            check_val("res_count", res_count, m_unload ? m_cnt[m_next_ch] : 0);
            check_val("res_ovf", res_ovf, m_unload ? m_ovf[m_next_ch] : 1'b0);
            check_val("meas_done", meas_done, m_unload && res_ready && (m_next_ch == NCH - 1));
        end
    end

    // Capture accepted results and handshake statistics for literal checks.
    int done_cnt = 0;
    int stall_cnt = 0;
    int acc_chan [$];
    logic [CNT_W-1:0] got_cnt [NCH];
    logic got_ovf [NCH];
    always @(negedge ref_clk) begin
        if (m_started) begin
            if (meas_done === 1'b1) done_cnt++;
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                acc_chan.push_back(int'(res_chan));
                got_cnt[res_chan] = res_count;
                got_ovf[res_chan] = res_ovf;
            end
            if (res_valid === 1'b1 && res_ready === 1'b0 && res_chan == 2'd1) stall_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic m, input logic with_stop);
        mode = m;
        start = 1'b1;
        stop = with_stop;
        tick(1);
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check_val({name, "_idle_timeout"}, busy, 0);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check_val({name, "_valid_timeout"}, res_valid, 1);
    endtask

    task automatic clear_capture();
        acc_chan.delete();
        for (int c = 0; c < NCH; c++) begin
            got_cnt[c] = '1;
            got_ovf[c] = 1'bx;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int d0;
    int lat;

    initial begin
        reset_n = 1'b0;
        gate_len = 12'd120;
        mode = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        res_ready = 1'b1;
        per[0] = 10; per[1] = 20; per[2] = 40; per[3] = -1;
        tick(3);
        check_val("reset_busy", busy, 0);
        check_val("reset_valid", res_valid, 0);
        check_val("reset_count", res_count, 0);
        reset_n = 1'b1;
        tick(5);

        $display("[TB] periods 10/20/40 plus held-high channel, gate 120");
        clear_capture();
        d0 = done_cnt;
        pulse_start(1'b0, 1'b0);
        wait_idle(300, "t1");
        check_val("t1_ch0", got_cnt[0], 12);
        check_val("t1_ch1", got_cnt[1], 6);
        check_val("t1_ch2", got_cnt[2], 3);
        check_val("t1_ch3", got_cnt[3], 0);
        for (int c = 0; c < NCH; c++) check_val("t1_ovf", got_ovf[c], 0);
        check_val("t1_done", done_cnt - d0, 1);

        $display("[TB] saturation: period 2 on ch0, gate 40");
        per[0] = 2; per[1] = 0; per[2] = 0; per[3] = 0;
        gate_len = 12'd40;
        tick(4);
        clear_capture();
        pulse_start(1'b0, 1'b0);
        wait_idle(200, "t2");
        check_val("t2_ch0", got_cnt[0], 15);
        check_val("t2_ovf0", got_ovf[0], 1);
        for (int c = 1; c < NCH; c++) begin
            check_val("t2_cnt", got_cnt[c], 0);
            check_val("t2_ovf", got_ovf[c], 0);
        end

        $display("[TB] back-pressure on ch1");
        per[0] = 10; per[1] = 20; per[2] = 40; per[3] = -1;
        gate_len = 12'd30;
        tick(5);
        clear_capture();
        stall_cnt = 0;
        res_ready = 1'b0;
        pulse_start(1'b0, 1'b0);
        wait_valid(100, "t3");
        check_val("t3_first_chan", res_chan, 0);
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        check_val("t3_stall_chan", res_chan, 1);
        tick(5);
        check_val("t3_held_chan", res_chan, 1);
        check_val("t3_held_valid", res_valid, 1);
        res_ready = 1'b1;
        tick(1);
        check_val("t3_next_chan", res_chan, 2);
        wait_idle(50, "t3");
        check_val("t3_stall_cycles", stall_cnt, 5);
        check_val("t3_accepts", acc_chan.size(), 4);
        for (int i = 0; i < acc_chan.size(); i++) check_val("t3_order", acc_chan[i], i);

        $display("[TB] continuous mode with stop in second gate");
        gate_len = 12'd20;
        d0 = done_cnt;
        pulse_start(1'b1, 1'b0);
        lat = 0;
        while (done_cnt == d0 && lat < 100) begin
            tick(1);
            lat++;
        end
        check_val("t4_first_done", done_cnt - d0, 1);
        tick(8);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle(200, "t4");
        check_val("t4_done", done_cnt - d0, 2);
        tick(20);
        check_val("t4_stays_idle", busy, 0);
        check_val("t4_no_third", done_cnt - d0, 2);

        $display("[TB] reset during gate, then zero gate length");
        gate_len = 12'd60;
        pulse_start(1'b0, 1'b0);
        tick(10);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check_val("t5_busy", busy, 0);
        check_val("t5_valid", res_valid, 0);
        check_val("t5_done", meas_done, 0);
        check_val("t5_count", res_count, 0);
        tick(3);
        gate_len = 12'd0;
        pulse_start(1'b0, 1'b0);
        lat = 1;
        while (res_valid !== 1'b1 && lat < 20) begin
            tick(1);
            lat++;
        end
        check_val("t5_latency", lat, 3);
        wait_idle(50, "t5");

        $display("[TB] start ignored while unloading; start with stop in IDLE");
        gate_len = 12'd10;
        d0 = done_cnt;
        pulse_start(1'b0, 1'b0);
        wait_valid(50, "t6");
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(50, "t6a");
        tick(10);
        check_val("t6_single", done_cnt - d0, 1);
        check_val("t6_idle", busy, 0);
        d0 = done_cnt;
        pulse_start(1'b1, 1'b1);
        wait_idle(100, "t6b");
        tick(20);
        check_val("t6_start_stop", done_cnt - d0, 1);
        check_val("t6b_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_freq_counter_mc.md
# temp_freq_counter_mc

Multi-channel, single-clock frequency counter for the temperature-sensor ring oscillators. Each channel synchronises its asynchronous oscillator input to `ref_clk` and counts rising edges over a programmable gate window. Counts saturate instead of wrapping. Results are handed to the readout logic channel by channel over a valid/ready interface, in single-shot or continuous mode.

## Interface
Parameters:
- `NCH`, 4, number of oscillator channels (≥1)
- `CNT_W`, 20, edge-counter width per channel
- `GATE_W`, 12, gate-length width
- `SYNC_STAGES`, 2, synchroniser flops per channel (≥2)

Ports:
- `ref_clk` in 1: sole clock; all logic on rising edge
- `reset_n` in 1: synchronous, active-low reset
- `sense_in` in NCH: asynchronous oscillator inputs; bit i belongs to channel i
- `gate_len` in GATE_W: gate length in `ref_clk` cycles, sampled on entry to CLR; 0 is treated as 1
- `mode` in 1: 0 = single-shot, 1 = continuous; sampled with `start`
- `start` in 1: one-cycle pulse that arms a measurement; ignored unless in IDLE
- `stop` in 1: one-cycle pulse that ends continuous mode after the current measurement
- `busy` out 1: high in any state except IDLE
- `res_valid` out 1: result offered
- `res_ready` in 1: consumer accepts the result when `res_valid && res_ready`
- `res_chan` out $clog2(NCH) (min 1): channel index of the offered result
- `res_count` out CNT_W: edge count of the offered result
- `res_ovf` out 1: the offered channel saturated
- `meas_done` out 1: one-cycle pulse on acceptance of the last channel

## Operation
- FSM states: IDLE, CLR, GATE, UNLOAD.
- IDLE:
  - `start` goes to CLR and latches `mode` into `cont`.
- CLR (1 cycle):
  - All counters and ovf flags are cleared.
  - `gate_len` is loaded into the gate down-counter.
  - Next state is GATE.
- GATE (exactly max(`gate_len`,1) cycles):
  - A channel increments on each cycle its edge-detect pulse is high.
  - At all-ones the counter holds and sets ovf; ovf is sticky until CLR.
  - Next state is UNLOAD.
- UNLOAD:
  - Channels are presented in order 0..NCH-1.
  - The index advances on each handshake.
  - On acceptance of channel NCH-1:
    - `meas_done` pulses.
    - Next state is CLR if `cont` is 1 and no stop is pending, otherwise IDLE.
- Edge detect:
  - Sync chain plus a previous-value flop.
  - Runs continuously and is cleared only by reset.
  - An input already high when GATE begins does not count.
- `stop` in any non-IDLE state sets the pending flag, which clears on IDLE entry.
- `stop` in IDLE is ignored.
- `start` and `stop` in the same IDLE cycle give one single-shot measurement.
- Counters are frozen outside GATE, so unload reads the counters directly; there is no snapshot copy.

## Timing
- Reset values:
  - `busy`, `res_valid`, `res_chan`, `res_count`, `res_ovf`, `meas_done` are all 0.
  - FSM is in IDLE.
  - Counters, sync chains and edge flops are 0.
- `start` sampled at edge t:
  - CLR in cycle t+1.
  - GATE in cycles t+2 .. t+1+G, where G = max(`gate_len`,1).
  - UNLOAD from t+2+G; `res_valid` rises in that same cycle.
- `busy` rises at t+1 and falls in the cycle IDLE is re-entered.
- Edge latency: an input edge is counted if its detect pulse falls inside GATE. The detect pulse follows the sync chain, SYNC_STAGES+1 edges after sampling.
- Measurable input rate is below `ref_clk`/2. Faster inputs alias; this is not flagged.
- Handshake rules:
  - While `res_valid && !res_ready`, `res_chan`, `res_count` and `res_ovf` are stable.
  - With `res_ready` tied high, one channel is accepted per cycle, giving NCH cycles of UNLOAD.
- `res_valid` deasserts in the cycle after the last acceptance.
- Continuous mode: the next CLR is the cycle after the last acceptance. Back-pressure delays the next gate; it never overlaps it.
- `reset_n` low mid-operation: on the next edge, everything returns to reset values. Partial results are discarded.

## Structure
- Package `temp_freq_pkg`:
  - State enum typedef (IDLE, CLR, GATE, UNLOAD).
  - Helper function for the channel-index width.
- Sub-module `temp_freq_chan`, instantiated NCH times:
  - Synchroniser and edge detector.
  - Saturating CNT_W counter.
  - Sticky ovf.
  - Inputs: `clr`, `en`.
- Top level: FSM, gate counter, unload mux.

## Test plan
- NCH=4, `gate_len`=120, bench drives `sense_in` from `ref_clk` with periods 10/20/40 on ch0–2 and ch3 held high from before `start` -> counts 12/6/3/0, ovf all 0, `meas_done` once, `busy` low after.
- CNT_W=4, `gate_len`=40, period 2 on ch0 -> ch0 count 15 with ovf=1, other channels 0 with ovf=0.
- `res_ready` low for 5 cycles while ch1 is offered -> `res_chan`=1 and its count held stable, `res_valid` stays high, the next offer is ch2.
- `mode`=1, `stop` pulsed mid-second GATE -> second measurement fully unloaded, 2 `meas_done` pulses total, IDLE afterwards with no third CLR.
- `reset_n` low 1 cycle during GATE -> all outputs 0 next cycle. A following `start` with `gate_len`=0 gives a 1-cycle GATE.
- `start` pulsed during UNLOAD -> ignored, no extra measurement. `start` and `stop` together in IDLE with `mode`=1 -> exactly one measurement.
